// File: rtl/bus_periph_responder_if.sv
// ---------------------------------------------------------------------------
// bus_periph_responder_if
// Bundles the CPU external data bus, the TX byte stream and the interrupt
// line of bus_periph_responder.
//   ADDR[31:0], Data_BUS_WRITE[31:0], CS, WR_RD : CPU -> responder
//   Data_BUS_READ[31:0]                         : responder -> CPU (registered)
//   TX_DATA[7:0], TX_VALID                      : responder -> sink
//   TX_READY                                    : sink -> responder
//   IRQ                                         : responder -> CPU (level)
// Modports: master = CPU/sink side, slave = responder side.
// ---------------------------------------------------------------------------
interface bus_periph_responder_if;
   logic [31:0] ADDR;
   logic [31:0] Data_BUS_WRITE;
   logic        CS;
   logic        WR_RD;
   logic [31:0] Data_BUS_READ;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic        IRQ;

   modport master (
      output ADDR, Data_BUS_WRITE, CS, WR_RD, TX_READY,
      input  Data_BUS_READ, TX_DATA, TX_VALID, IRQ
   );

   modport slave (
      input  ADDR, Data_BUS_WRITE, CS, WR_RD, TX_READY,
      output Data_BUS_READ, TX_DATA, TX_VALID, IRQ
   );
endinterface

// File: rtl/bus_periph_responder.sv
// ---------------------------------------------------------------------------
// bus_periph_responder
// Memory-mapped responder on the CPU external data bus. Decodes a 32-byte
// window at BASE_ADDR holding CTRL, STATUS, TIMER, COMPARE, TXDATA (TX FIFO
// push) and SCRATCH. The TX FIFO drains over a valid/ready byte stream and
// the timer raises a level interrupt on TIMER==COMPARE.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous, active-high reset
//   bus  : bus_periph_responder_if.slave (CPU bus, TX stream, IRQ)
// Parameters:
//   BASE_ADDR  : window base, ADDR[31:5] compared against BASE_ADDR[31:5]
//   FIFO_DEPTH : TX FIFO entries, power of 2 in 2..16
// Configuration macro:
//   PERIPH_IRQ_EN : when defined, CTRL.ie / STATUS.pend / IRQ are live;
//                   otherwise IRQ is 0 and those bits read 0, ignore writes.
// ---------------------------------------------------------------------------
module bus_periph_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic                    CLK,
   input logic                    RST,
   bus_periph_responder_if.slave  bus
);

   localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned      CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      OFF_CTRL    = 3'd0,
      OFF_STATUS  = 3'd1,
      OFF_TIMER   = 3'd2,
      OFF_COMPARE = 3'd3,
      OFF_TXDATA  = 3'd4,
      OFF_SCRATCH = 3'd5,
      OFF_RSVD6   = 3'd6,
      OFF_RSVD7   = 3'd7
   } offset_e;

   // Decode
   offset_e     off;
   logic        sel, wr, rd;
   logic [31:0] wdata;
   logic        unused_addr_lsb;

   assign sel             = bus.CS && (bus.ADDR[31:5] == BASE_ADDR[31:5]);
   assign wr              = sel && bus.WR_RD;
   assign rd              = sel && !bus.WR_RD;
   assign off             = offset_e'(bus.ADDR[4:2]);
   assign wdata           = bus.Data_BUS_WRITE;
   assign unused_addr_lsb = ^bus.ADDR[1:0];

   // State
   logic                        ten_q, ten_d;
   logic                        ie_q, ie_d;
   logic                        pend_q, pend_d;
   logic                        ovf_q, ovf_d;
   logic [31:0]                 timer_q, timer_d;
   logic [31:0]                 compare_q, compare_d;
   logic [31:0]                 scratch_q, scratch_d;
   logic [31:0]                 rdata_q, rdata_d;
   logic [FIFO_DEPTH-1:0][7:0]  mem_q, mem_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        tx_valid_q, tx_valid_d;
   logic [7:0]                  tx_data_q, tx_data_d;
   logic                        irq_q, irq_d;

   // Combinational helpers
   logic        pend_set, pop, push, push_ok, full, flush;
   logic [31:0] status_w;

   always_comb begin
      ten_d     = ten_q;
      ie_d      = ie_q;
      pend_d    = pend_q;
      ovf_d     = ovf_q;
      timer_d   = timer_q;
      compare_d = compare_q;
      scratch_d = scratch_q;
      rdata_d   = rdata_q;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      push_ok   = 1'b0;

      pend_set = ten_q && (timer_q == compare_q);
      pop      = tx_valid_q && bus.TX_READY;
      push     = wr && (off == OFF_TXDATA);
      full     = (count_q == CNT_FULL);
      flush    = wr && (off == OFF_CTRL) && wdata[2];

      // STATUS view of pre-edge state
      status_w      = '0;
      status_w[0]   = (count_q == '0);
      status_w[1]   = full;
      status_w[2]   = pend_q;
      status_w[3]   = ovf_q;
      status_w[8:4] = 5'(count_q);

      // Timer: wrap to 0 on compare match instead of incrementing
      if (ten_q) begin
         timer_d = pend_set ? '0 : timer_q + 32'd1;
      end

      // CPU writes; a TIMER write overrides the increment/wrap above
      if (wr) begin
         case (off)
            OFF_CTRL: begin
               ten_d = wdata[0];
`ifdef PERIPH_IRQ_EN
               ie_d  = wdata[1];
`endif
            end
            OFF_STATUS: begin
`ifdef PERIPH_IRQ_EN
               if (wdata[2]) pend_d = 1'b0;
`endif
               if (wdata[3]) ovf_d = 1'b0;
            end
            OFF_TIMER:   timer_d   = wdata;
            OFF_COMPARE: compare_d = wdata;
            OFF_SCRATCH: scratch_d = wdata;
            default: ;
         endcase
      end

`ifdef PERIPH_IRQ_EN
      // Set after the write-1-clear so a same-cycle match wins
      if (pend_set) pend_d = 1'b1;
`endif

      // TX FIFO; flush overrides push and pop
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // A full FIFO still accepts a push when the head leaves this cycle
         push_ok = push && (!full || pop);
         if (push && full && !pop) ovf_d = 1'b1;
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!push_ok && pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end

      // Stream outputs registered from next FIFO state
      tx_valid_d = (count_d != '0);
      tx_data_d  = mem_d[rd_ptr_d];

`ifdef PERIPH_IRQ_EN
      irq_d = pend_d && ie_d;
`else
      irq_d = 1'b0;
`endif

      // Read data changes only on a read cycle
      if (rd) begin
         case (off)
            OFF_CTRL:    rdata_d = {30'd0, ie_q, ten_q};
            OFF_STATUS:  rdata_d = status_w;
            OFF_TIMER:   rdata_d = timer_q;
            OFF_COMPARE: rdata_d = compare_q;
            OFF_SCRATCH: rdata_d = scratch_q;
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ten_q      <= 1'b0;
         ie_q       <= 1'b0;
         pend_q     <= 1'b0;
         ovf_q      <= 1'b0;
         timer_q    <= '0;
         compare_q  <= '1;
         scratch_q  <= '0;
         rdata_q    <= '0;
         mem_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         ten_q      <= ten_d;
         ie_q       <= ie_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         timer_q    <= timer_d;
         compare_q  <= compare_d;
         scratch_q  <= scratch_d;
         rdata_q    <= rdata_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.Data_BUS_READ = rdata_q;
   assign bus.TX_VALID      = tx_valid_q;
   assign bus.TX_DATA       = tx_data_q;
   assign bus.IRQ           = irq_q;

endmodule

// File: tb/tb_bus_periph_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_periph_responder
// Directed bench for bus_periph_responder with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
// Honours PERIPH_IRQ_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_bus_periph_responder;

`ifdef PERIPH_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif
   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_periph_responder_if bus_if ();

   bus_periph_responder #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %0s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_ten, m_ie, m_pend, m_ovf, m_irq;
   logic [31:0] m_timer, m_compare, m_scratch, m_rdata;
   byte unsigned m_fifo[$];

   task automatic m_reset();
      m_ten = 0; m_ie = 0; m_pend = 0; m_ovf = 0; m_irq = 0;
      m_timer = 0; m_compare = 32'hFFFF_FFFF; m_scratch = 0; m_rdata = 0;
      m_fifo.delete();
   endtask

   function automatic logic [31:0] m_read(input int off);
      logic [31:0] s;
      s = '0;
      case (off)
         0: s = {30'd0, m_ie, m_ten};
         1: begin
            s[0]   = (m_fifo.size() == 0);
            s[1]   = (m_fifo.size() == DEPTH);
            s[2]   = m_pend;
            s[3]   = m_ovf;
            s[8:4] = 5'(m_fifo.size());
         end
         2: s = m_timer;
         3: s = m_compare;
         5: s = m_scratch;
         default: s = '0;
      endcase
      return s;
   endfunction

   task automatic m_step();
      logic [31:0] a, wd, nrd;
      int off;
      bit sel, wr, rd, was_full, pop, hit;
      a        = bus_if.ADDR;
      wd       = bus_if.Data_BUS_WRITE;
      off      = int'(a[4:2]);
      sel      = bus_if.CS && (a[31:5] == BASE[31:5]);
      wr       = sel && bus_if.WR_RD;
      rd       = sel && !bus_if.WR_RD;
      was_full = (m_fifo.size() == DEPTH);
      pop      = (m_fifo.size() != 0) && bus_if.TX_READY;
      hit      = m_ten && (m_timer == m_compare);
      nrd      = rd ? m_read(off) : m_rdata;
      if (m_ten) m_timer = hit ? 32'd0 : m_timer + 32'd1;
      if (wr && off == 0 && wd[2]) begin
         m_fifo.delete();
      end else begin
         if (pop) void'(m_fifo.pop_front());
         if (wr && off == 4) begin
            if (was_full && !pop) m_ovf = 1;
            else m_fifo.push_back(wd[7:0]);
         end
      end
      if (wr) begin
         case (off)
            0: begin m_ten = wd[0]; m_ie = IRQ_EN && wd[1]; end
            1: begin if (wd[2]) m_pend = 0; if (wd[3]) m_ovf = 0; end
            2: m_timer = wd;
            3: m_compare = wd;
            5: m_scratch = wd;
            default: ;
         endcase
      end
      if (hit && IRQ_EN) m_pend = 1;
      m_rdata = nrd;
      m_irq   = m_pend && m_ie;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else m_step();
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("cyc_rdata", bus_if.Data_BUS_READ, m_rdata);
         check("cyc_tx_valid", 32'(bus_if.TX_VALID), 32'(m_fifo.size() != 0));
         if (m_fifo.size() != 0) check("cyc_tx_data", 32'(bus_if.TX_DATA), 32'(m_fifo[0]));
         check("cyc_irq", 32'(bus_if.IRQ), 32'(m_irq));
      end
   end

   // Sink: record bytes that transfer at the upcoming edge
   byte unsigned got[$];
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus_if.TX_VALID && bus_if.TX_READY) got.push_back(bus_if.TX_DATA);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus_if.CS = 1'b1; bus_if.WR_RD = 1'b1; bus_if.ADDR = a; bus_if.Data_BUS_WRITE = d;
      tick();
      bus_if.CS = 1'b0; bus_if.WR_RD = 1'b0;
   endtask

   task automatic bus_write_nocs(input logic [31:0] a, input logic [31:0] d);
      bus_if.CS = 1'b0; bus_if.WR_RD = 1'b1; bus_if.ADDR = a; bus_if.Data_BUS_WRITE = d;
      tick();
      bus_if.WR_RD = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      bus_if.CS = 1'b1; bus_if.WR_RD = 1'b0; bus_if.ADDR = a;
      tick();
      bus_if.CS = 1'b0;
   endtask

   task automatic check_sink(input string name, input byte unsigned exp[$]);
      check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++) begin
         if (i < got.size()) check(name, 32'(got[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      byte unsigned exp_q[$];
      bus_if.CS = 1'b0; bus_if.WR_RD = 1'b0; bus_if.ADDR = '0;
      bus_if.Data_BUS_WRITE = '0; bus_if.TX_READY = 1'b0;

      // 1: reset values
      tick(); tick();
      check("rst_rdata", bus_if.Data_BUS_READ, 32'h0);
      check("rst_tx_valid", 32'(bus_if.TX_VALID), 32'h0);
      check("rst_tx_data", 32'(bus_if.TX_DATA), 32'h0);
      check("rst_irq", 32'(bus_if.IRQ), 32'h0);
      rst = 1'b0;
      tick();
      bus_read(32'h0000_200C);
      check("rst_compare", bus_if.Data_BUS_READ, 32'hFFFF_FFFF);

      // 2: scratch, deselected writes, reserved offsets
      bus_write(32'h0000_2014, 32'hDEAD_BEEF);
      bus_read(32'h0000_2014);
      check("scratch_rd", bus_if.Data_BUS_READ, 32'hDEAD_BEEF);
      bus_write_nocs(32'h0000_2014, 32'h1234_5678);
      bus_write(32'h0000_3014, 32'h1234_5678);
      tick();
      check("rdata_held", bus_if.Data_BUS_READ, 32'hDEAD_BEEF);
      bus_read(32'h0000_2014);
      check("scratch_unchanged", bus_if.Data_BUS_READ, 32'hDEAD_BEEF);
      bus_write(32'h0000_2018, 32'hFFFF_FFFF);
      bus_read(32'h0000_2018);
      check("rsvd_rd0", bus_if.Data_BUS_READ, 32'h0);

      // 3: timer, compare match, pend/IRQ, write-1-clear
      bus_write(32'h0000_200C, 32'd5);
      bus_write(32'h0000_2000, 32'd3);
      repeat (5) tick();
      check("irq_before_match", 32'(bus_if.IRQ), 32'h0);
      tick();
      check("irq_after_match", 32'(bus_if.IRQ), 32'(IRQ_EN));
      bus_read(32'h0000_2008);
      check("timer_wrapped", bus_if.Data_BUS_READ, 32'h0);
      bus_read(32'h0000_2004);
      check("status_pend", bus_if.Data_BUS_READ, IRQ_EN ? 32'h5 : 32'h1);
      bus_write(32'h0000_2004, 32'h4);
      check("irq_cleared", 32'(bus_if.IRQ), 32'h0);
      bus_write(32'h0000_2000, 32'h0);
      bus_read(32'h0000_2008);
      check("timer_stopped", bus_if.Data_BUS_READ, 32'd4);

      // 4: overflow with sink stalled, then drain
      bus_if.TX_READY = 1'b0;
      for (int i = 1; i <= 9; i++) bus_write(32'h0000_2010, 32'(i));
      bus_read(32'h0000_2004);
      check("status_full_ovf", bus_if.Data_BUS_READ, 32'h8A);
      got.delete();
      bus_if.TX_READY = 1'b1;
      repeat (12) tick();
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      check_sink("drain1", exp_q);
      bus_read(32'h0000_2004);
      check("status_empty_ovf", bus_if.Data_BUS_READ, 32'h9);
      bus_write(32'h0000_2004, 32'h8);
      bus_read(32'h0000_2004);
      check("status_ovf_clr", bus_if.Data_BUS_READ, 32'h1);

      // 5: push into a full FIFO while the head leaves
      bus_if.TX_READY = 1'b0;
      for (int i = 0; i < 8; i++) bus_write(32'h0000_2010, 32'(8'h11 + i));
      bus_read(32'h0000_2004);
      check("status_full", bus_if.Data_BUS_READ, 32'h82);
      got.delete();
      bus_if.TX_READY = 1'b1;
      bus_write(32'h0000_2010, 32'hAA);
      bus_if.TX_READY = 1'b0;
      bus_read(32'h0000_2004);
      check("status_full_pushpop", bus_if.Data_BUS_READ, 32'h82);
      bus_if.TX_READY = 1'b1;
      repeat (12) tick();
      exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
      check_sink("drain2", exp_q);

      // Flush with a same-cycle pop
      bus_if.TX_READY = 1'b0;
      for (int i = 0; i < 3; i++) bus_write(32'h0000_2010, 32'(8'h21 + i));
      bus_if.TX_READY = 1'b1;
      bus_write(32'h0000_2000, 32'h4);
      bus_if.TX_READY = 1'b0;
      check("flush_tx_valid", 32'(bus_if.TX_VALID), 32'h0);
      bus_read(32'h0000_2000);
      check("ctrl_flush_rd0", bus_if.Data_BUS_READ, 32'h0);
      bus_read(32'h0000_2004);
      check("flush_status", bus_if.Data_BUS_READ, 32'h1);

      // 6: asynchronous reset during a read with timer running
      bus_write(32'h0000_2010, 32'h5A);
      bus_write(32'h0000_2000, 32'h3);
      tick(); tick();
      check("pre_rst_irq", 32'(bus_if.IRQ), 32'(IRQ_EN));
      check("pre_rst_tx_valid", 32'(bus_if.TX_VALID), 32'h1);
      bus_if.CS = 1'b1; bus_if.WR_RD = 1'b0; bus_if.ADDR = 32'h0000_2008;
      #1 rst = 1'b1;
      #1;
      check("arst_rdata", bus_if.Data_BUS_READ, 32'h0);
      check("arst_tx_valid", 32'(bus_if.TX_VALID), 32'h0);
      check("arst_tx_data", 32'(bus_if.TX_DATA), 32'h0);
      check("arst_irq", 32'(bus_if.IRQ), 32'h0);
      bus_if.CS = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      bus_read(32'h0000_200C);
      check("arst_compare", bus_if.Data_BUS_READ, 32'hFFFF_FFFF);
      bus_read(32'h0000_2008);
      check("arst_timer", bus_if.Data_BUS_READ, 32'h0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
